ahb_master_interface: RTL and testbench

AHB_MASTER_INTERFACE -- requirements
Module: ahb_master_interface

---
 rtl/ahb_master_interface.sv | 180 ++++++++++++++++++
 tb/tb_ahb_master_interface.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_interface.sv
// AHB-Lite master front end: turns SINGLE/INCR4 read/write commands into
// pipelined AHB address/data phases, with legality screening and error abort.
module ahb_master_interface #(
  parameter logic [31:0] ADDR_LO = 32'h8000_0000,
  parameter logic [31:0] ADDR_HI = 32'h8C00_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_burst,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic        Hreadyin,
  input  logic [1:0]  Hresp,
  input  logic [31:0] Hrdata,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [2:0]  Hsize,
  output logic [2:0]  Hburst,
  output logic [31:0] Hwdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_LAST  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_BUSY    = 2'b01;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] HB_SINGLE  = 3'b000;
  localparam logic [2:0] HB_INCR4   = 3'b011;

  // An INCR4 starting above offset 0x3F0 would cross a 1 KB boundary.
  function automatic logic cmd_legal(input logic [31:0] a, input logic incr4);
    return (a >= ADDR_LO) && (a < ADDR_HI) && (a[1:0] == 2'b00) &&
           !(incr4 && (a[9:0] > 10'h3F0));
  endfunction

  state_t      state_r, state_s;
  logic [31:0] addr_r, hwdata_r, rdata_r;
  logic [2:0]  hburst_r, beats_left_r;
  logic        write_r, first_r, dphase_r, rdata_valid_r, err_r;
  logic        legal_s, issue_s, addr_done_s, dphase_err_s;
  logic [1:0]  htrans_s;

  assign legal_s      = cmd_legal(cmd_addr, cmd_burst);
  assign addr_done_s  = issue_s && Hreadyin;
  assign dphase_err_s = dphase_r && !Hreadyin && (Hresp == RESP_ERROR);

  // Transfer type: a write beat is only presented once its data is available.
  always_comb begin
    issue_s  = 1'b0;
    htrans_s = TR_IDLE;
    if (state_r == S_ADDR) begin
      issue_s = !write_r || wdata_valid;
      if (issue_s) begin
        htrans_s = first_r ? TR_NONSEQ : TR_SEQ;
      end else begin
        htrans_s = first_r ? TR_IDLE : TR_BUSY;
      end
    end else begin
      htrans_s = TR_IDLE;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid && legal_s) state_s = S_ADDR;
        else                      state_s = S_IDLE;
      end
      S_ADDR: begin
        if (dphase_err_s)                             state_s = S_ABORT;
        else if (addr_done_s && beats_left_r == 3'd1) state_s = S_LAST;
        else                                          state_s = S_ADDR;
      end
      S_LAST: begin
        if (dphase_err_s)  state_s = S_ABORT;
        else if (Hreadyin) state_s = S_IDLE;
        else               state_s = S_LAST;
      end
      S_ABORT: begin
        if (Hreadyin) state_s = S_IDLE;
        else          state_s = S_ABORT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Hclk) begin
    if (Hreset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Datapath: command latch, beat advance, write/read data capture, strobes
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      addr_r        <= 32'h0000_0000;
      write_r       <= 1'b0;
      hburst_r      <= HB_SINGLE;
      hwdata_r      <= 32'h0000_0000;
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
      err_r         <= 1'b0;
      beats_left_r  <= 3'd0;
      first_r       <= 1'b0;
      dphase_r      <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      err_r         <= 1'b0;
      case (state_r)
        S_IDLE: begin
          dphase_r <= 1'b0;
          if (cmd_valid && legal_s) begin
            addr_r       <= cmd_addr;
            write_r      <= cmd_write;
            hburst_r     <= cmd_burst ? HB_INCR4 : HB_SINGLE;
            beats_left_r <= cmd_burst ? 3'd4 : 3'd1;
            first_r      <= 1'b1;
          end else if (cmd_valid) begin
            err_r <= 1'b1;
          end
        end
        S_ADDR, S_LAST: begin
          if (dphase_r && Hreadyin && !write_r && (Hresp == RESP_OKAY)) begin
            rdata_r       <= Hrdata;
            rdata_valid_r <= 1'b1;
          end
          // A completing address phase opens the next data phase.
          if (addr_done_s) begin
            addr_r       <= addr_r + 32'd4;
            beats_left_r <= beats_left_r - 3'd1;
            first_r      <= 1'b0;
            dphase_r     <= 1'b1;
            if (write_r) hwdata_r <= wdata;
          end else if (Hreadyin) begin
            dphase_r <= 1'b0;
          end
        end
        S_ABORT: begin
          dphase_r <= 1'b0;
          if (Hreadyin) err_r <= 1'b1;
        end
        default: dphase_r <= 1'b0;
      endcase
    end
  end

  assign cmd_ready   = (state_r == S_IDLE) && !Hreset;
  assign busy        = (state_r != S_IDLE);
  assign wdata_ready = addr_done_s && write_r;
  assign Haddr       = addr_r;
  assign Htrans      = htrans_s;
  assign Hwrite      = write_r;
  assign Hsize       = 3'b010;
  assign Hburst      = hburst_r;
  assign Hwdata      = hwdata_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign err         = err_r;

endmodule

// File: tb/tb_ahb_master_interface.sv
// Scoreboard bench: expected address phases, write data and read data are
// queued when each command is driven and popped as the bus shows them.
module tb_ahb_master_interface;

  logic        Hclk = 1'b0;
  logic        Hreset, cmd_valid, cmd_ready, cmd_write, cmd_burst;
  logic [31:0] cmd_addr, wdata, Hrdata, Haddr, Hwdata, rdata;
  logic        wdata_valid, wdata_ready, Hreadyin, Hwrite, rdata_valid, busy, err;
  logic [1:0]  Hresp, Htrans;
  logic [2:0]  Hsize, Hburst;

  localparam logic [31:0] RD_KEY = 32'h5A5A_A5A5;

  logic [33:0] addr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_cnt, wrdy_cnt, busytr_cnt;
  logic        wd_pend = 1'b0;
  logic        cur_wr, cur_bu;
  logic [31:0] hold_addr = 32'hFFFF_FFFF;

  ahb_master_interface dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_addr(cmd_addr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .Hreadyin(Hreadyin), .Hresp(Hresp), .Hrdata(Hrdata),
    .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
    .Hburst(Hburst), .Hwdata(Hwdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .err(err)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk_reset(input logic exp_cr);
    chk("rst_htrans", 32'(Htrans), 32'h0);
    chk("rst_haddr", Haddr, 32'h0);
    chk("rst_hwrite", 32'(Hwrite), 32'h0);
    chk("rst_hwdata", Hwdata, 32'h0);
    chk("rst_hburst", 32'(Hburst), 32'h0);
    chk("rst_hsize", 32'(Hsize), 32'h2);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(exp_cr));
  endtask

  // Bus monitor: pops the scoreboard as phases complete.
  always @(negedge Hclk) begin
    if (Hreset) begin
      wd_pend = 1'b0;
    end else begin
      if (err) err_cnt++;
      if (wdata_ready) wrdy_cnt++;
      if (Htrans == 2'b01) begin
        busytr_cnt++;
        chk("busy_haddr_held", Haddr, hold_addr);
      end
      if (rdata_valid) begin
        chk("rdata_expected", 32'(rd_q.size() != 0), 32'h1);
        if (rd_q.size() != 0) chk("rdata", rdata, rd_q.pop_front());
      end
      if (wd_pend) begin
        chk("hwdata_expected", 32'(wd_q.size() != 0), 32'h1);
        if (wd_q.size() != 0) chk("hwdata", Hwdata, wd_q[0]);
        if (Hreadyin) begin
          if (wd_q.size() != 0) void'(wd_q.pop_front());
          wd_pend = 1'b0;
        end
      end
      if (Htrans[1] && Hreadyin) begin
        chk("addr_phase_expected", 32'(addr_q.size() != 0), 32'h1);
        if (addr_q.size() != 0) begin
          logic [33:0] e;
          e = addr_q.pop_front();
          chk("haddr", Haddr, e[31:0]);
          chk("htrans", 32'(Htrans), 32'(e[33:32]));
          chk("hwrite", 32'(Hwrite), 32'(cur_wr));
          chk("hburst", 32'(Hburst), cur_bu ? 32'h3 : 32'h0);
        end
        if (Hwrite) wd_pend = 1'b1;
      end
    end
  end

  // Issue one command, then run n cycles with per-cycle Hreadyin/Hresp/wdata_valid bit patterns.
  task automatic xfer(input logic wr, input logic bu, input logic [31:0] a,
                      input logic [15:0] rdy, input logic [15:0] er, input logic [15:0] wv,
                      input int n, input int nbeats, input int nrd, input int nwd,
                      input int e_err, input int e_bsy, input int e_busytr,
                      input logic [31:0] wbase);
    int          wbeat, bsy;
    logic        hs, ac;
    logic [31:0] ac_addr;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    err_cnt = 0; wrdy_cnt = 0; busytr_cnt = 0; wbeat = 0; bsy = 0;
    cur_wr = wr; cur_bu = bu;
    for (int k = 0; k < nbeats; k++) addr_q.push_back({(k == 0) ? 2'b10 : 2'b11, a + 32'(4 * k)});
    for (int k = 0; k < nrd; k++) rd_q.push_back((a + 32'(4 * k)) ^ RD_KEY);
    for (int k = 0; k < nwd; k++) wd_q.push_back(wbase + 32'(k));
    cmd_valid = 1'b1; cmd_write = wr; cmd_burst = bu; cmd_addr = a;
    @(posedge Hclk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      Hreadyin    = rdy[i];
      Hresp       = er[i] ? 2'b01 : 2'b00;
      wdata_valid = wv[i];
      wdata       = wbase + 32'(wbeat);
      @(negedge Hclk);
      if (i == 0) chk("cmd_ready_c0", 32'(cmd_ready), 32'(e_bsy == 0));
      hs      = wdata_ready && wdata_valid;
      ac      = Htrans[1] && Hreadyin;
      ac_addr = Haddr;
      if (busy) bsy++;
      @(posedge Hclk); #1;
      if (hs) wbeat++;
      if (ac) Hrdata = ac_addr ^ RD_KEY;
    end
    Hreadyin = 1'b1; Hresp = 2'b00; wdata_valid = 1'b0;
    chk("err_strobes", 32'(err_cnt), 32'(e_err));
    chk("busy_cycles", 32'(bsy), 32'(e_bsy));
    chk("htrans_busy_cycles", 32'(busytr_cnt), 32'(e_busytr));
    chk("wdata_ready_pulses", 32'(wrdy_cnt), wr ? 32'(nbeats) : 32'h0);
    chk("addr_q_left", 32'(addr_q.size()), 32'h0);
    chk("rd_q_left", 32'(rd_q.size()), 32'h0);
    chk("wd_q_left", 32'(wd_q.size()), 32'h0);
    addr_q.delete(); rd_q.delete(); wd_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    Hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
    cmd_addr = 32'h0; wdata = 32'h0; wdata_valid = 1'b0;
    Hreadyin = 1'b1; Hresp = 2'b00; Hrdata = 32'h0;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    chk_reset(1'b0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    chk_reset(1'b1);
    @(posedge Hclk); #1;

    // SINGLE write, no waits
    xfer(1'b1, 1'b0, 32'h8000_0010, 16'hFFFF, 16'h0000, 16'hFFFF, 3, 1, 0, 1, 0, 2, 0, 32'hDEAD_BEEF);
    // INCR4 read, two wait states on beat 2 data phase
    xfer(1'b0, 1'b1, 32'h8400_0000, 16'hFFF3, 16'h0000, 16'hFFFF, 9, 4, 4, 0, 0, 7, 0, 32'h0);
    // INCR4 write, beat 3 data late for three cycles
    hold_addr = 32'h8800_0108;
    xfer(1'b1, 1'b1, 32'h8800_0100, 16'hFFFF, 16'h0000, 16'hFFE3, 10, 4, 0, 4, 0, 8, 3, 32'hC0DE_0000);
    hold_addr = 32'hFFFF_FFFF;
    // Rejected commands
    xfer(1'b0, 1'b0, 32'h7FFF_FFFC, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 0, 0, 0, 1, 0, 0, 32'h0);
    xfer(1'b1, 1'b0, 32'h8C00_0000, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 0, 0, 0, 1, 0, 0, 32'h0);
    xfer(1'b0, 1'b0, 32'h8000_0002, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 0, 0, 0, 1, 0, 0, 32'h0);
    xfer(1'b0, 1'b1, 32'h8000_03F4, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 0, 0, 0, 1, 0, 0, 32'h0);
    // Legal edges: INCR4 ending exactly at a 1 KB boundary, last word below ADDR_HI
    xfer(1'b0, 1'b1, 32'h8000_03F0, 16'hFFFF, 16'h0000, 16'hFFFF, 7, 4, 4, 0, 0, 5, 0, 32'h0);
    xfer(1'b0, 1'b0, 32'h8BFF_FFFC, 16'hFFFF, 16'h0000, 16'hFFFF, 4, 1, 1, 0, 0, 2, 0, 32'h0);
    // ERROR response on beat 1 of INCR4 read
    xfer(1'b0, 1'b1, 32'h8000_0200, 16'hFFFD, 16'h0006, 16'hFFFF, 5, 1, 0, 0, 1, 3, 0, 32'h0);
    // Reset asserted during beat 2 of an INCR4 write
    xfer(1'b1, 1'b1, 32'h8000_0400, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 2, 0, 1, 0, 2, 0, 32'h1234_0000);
    Hreset = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    chk_reset(1'b1);
    @(posedge Hclk); #1;
    // Recovery after reset
    xfer(1'b0, 1'b0, 32'h8000_0020, 16'hFFFF, 16'h0000, 16'hFFFF, 4, 1, 1, 0, 0, 2, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
